// File: rtl/mem_bank_rw.sv
// mem_bank_rw: parametrised single-port word memory with valid/ready requests,
// per-byte write enables, a RD_LATENCY-deep read pipeline and a sweep-clear engine.
// Optional build macro MEM_BANK_PARITY_EN adds per-lane even parity
// (Parity_err output, Par_inject input).
module mem_bank_rw #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    Req_valid,
  output logic                    Req_ready,
  input  logic                    Req_write,
  input  logic [ADDR_WIDTH-1:0]   Req_addr,
  input  logic [DATA_WIDTH-1:0]   Req_wdata,
  input  logic [DATA_WIDTH/8-1:0] Req_be,
  input  logic                    Clr_start,
  output logic                    Clr_busy,
  output logic [DATA_WIDTH-1:0]   Rd_data,
  output logic                    Rd_valid
`ifdef MEM_BANK_PARITY_EN
  ,
  output logic                    Parity_err,
  input  logic                    Par_inject
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned NB    = DATA_WIDTH / 8;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;

  logic                    accept;
  logic                    wr_fire;
  logic                    rd_fire;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [NB-1:0]           mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   rd_word;

  logic [RD_LATENCY-1:0]   pipe_v;
  logic [DATA_WIDTH-1:0]   pipe_d [RD_LATENCY];

`ifdef MEM_BANK_PARITY_EN
  logic [NB-1:0]           par_mem [DEPTH];
  logic [NB-1:0]           mem_wpar;
  logic                    rd_perr;
  logic [RD_LATENCY-1:0]   pipe_e;
`endif

  // State and sweep-address register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, sweep counter and handshake outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    Clr_busy  = 1'b0;
    Req_ready = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        Clr_busy = 1'b1;
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_IDLE: begin
        Req_ready = !Clr_start;
        if (Clr_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign accept  = Req_valid && Req_ready;
  assign wr_fire = accept && Req_write;
  assign rd_fire = accept && !Req_write;

  // Single write port shared by the clear sweep and accepted writes
  always_comb begin
    mem_we    = '0;
    mem_waddr = Req_addr;
    mem_wdata = Req_wdata;
`ifdef MEM_BANK_PARITY_EN
    mem_wpar  = '0;
`endif
    if (state_q == ST_CLEAR) begin
      mem_we    = '1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else if (wr_fire) begin
      mem_we = Req_be;
`ifdef MEM_BANK_PARITY_EN
      for (int unsigned k = 0; k < NB; k++) begin
        mem_wpar[k] = (^Req_wdata[8*k +: 8]) ^ Par_inject;
      end
`endif
    end
  end

  // Storage array (no reset; zeroed by the sweep)
  always_ff @(posedge CLK) begin
    for (int unsigned k = 0; k < NB; k++) begin
      if (mem_we[k]) begin
        mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
`ifdef MEM_BANK_PARITY_EN
        par_mem[mem_waddr][k] <= mem_wpar[k];
`endif
      end
    end
  end

  assign rd_word = mem[Req_addr];

`ifdef MEM_BANK_PARITY_EN
  // Recompute lane parity of the word being read and compare with stored bits
  always_comb begin
    rd_perr = 1'b0;
    for (int unsigned k = 0; k < NB; k++) begin
      rd_perr = rd_perr | ((^rd_word[8*k +: 8]) ^ par_mem[Req_addr][k]);
    end
  end
`endif

  // Read pipeline; data stages load only behind a valid so Rd_data holds otherwise
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pipe_v <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        pipe_d[i] <= '0;
      end
`ifdef MEM_BANK_PARITY_EN
      pipe_e <= '0;
`endif
    end else begin
      pipe_v[0] <= rd_fire;
      if (rd_fire) begin
        pipe_d[0] <= rd_word;
      end
`ifdef MEM_BANK_PARITY_EN
      pipe_e[0] <= rd_fire && rd_perr;
`endif
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) begin
          pipe_d[i] <= pipe_d[i-1];
        end
`ifdef MEM_BANK_PARITY_EN
        pipe_e[i] <= pipe_e[i-1];
`endif
      end
    end
  end

  assign Rd_valid = pipe_v[RD_LATENCY-1];
  assign Rd_data  = pipe_d[RD_LATENCY-1];
`ifdef MEM_BANK_PARITY_EN
  assign Parity_err = pipe_v[RD_LATENCY-1] && pipe_e[RD_LATENCY-1];
`endif

endmodule
